uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver that replaces the fixed 8N2 receiver feeding the frame-buffer write path. It adds configurable data width, stop-bit count, 16x oversampling with majority-vote sampling, optional parity, and a valid/ready output handshake with overrun reporting. It sits between the synchronised `UART_RXD` pin and the pixel-write logic that advances `write_addr`.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in baud.
- `OVERSAMPLE`, 16: sample ticks per bit; must be even and ≥8.
- `DATA_BITS`, 8: data bits per frame, 5–9, LSB first.
- `STOP_BITS`, 2: stop bits checked, 1 or 2.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 even. Used only with `UART_RX_PARITY_EN`.

Ports:
- `clk` in 1: system clock (CLOCK_50 at top level).
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input, idle high.
- `data_out` out DATA_BITS: received word, stable while `data_valid`=1.
- `data_valid` out 1: word available.
- `data_ready` in 1: consumer accepts the word when `data_valid && data_ready` on a rising edge.
- `frame_error` out 1: one-cycle pulse when a stop bit samples low.
- `parity_error` out 1: one-cycle pulse on parity mismatch. Tied 0 without the macro.
- `overrun` out 1: one-cycle pulse when a new word completes while the old one is unaccepted.
- `break_det` out 1: level, high while the line is held low after an all-zero frame.
- `state` out 3: current FSM state, for debug.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- Tick generator: counter wraps at `DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)`, integer truncated. At defaults DIV=27. It emits a 1-cycle `tick` and is held cleared in IDLE.
- Sample counter `s` runs 0..OVERSAMPLE-1 per bit. Each bit value is the majority of the samples at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
- FSM states and encoding:
  - IDLE=0: wait for synchronised rx=0, then go to START with s=0.
  - START=1: at the vote point, a majority of 1 is a false start and returns to IDLE with no flags. At s=OVERSAMPLE-1, go to DATA.
  - DATA=2: shift DATA_BITS votes in LSB first. After the last bit, go to PARITY if the macro is defined, otherwise to STOP.
  - PARITY=3: compare the received bit with the computed parity.
  - STOP=4: check STOP_BITS bits. At the vote of the final stop bit, the frame completes.
  - WAIT_IDLE=5: entered after a frame error. Stay until synchronised rx=1 for one full bit time, then go to IDLE.
- Frame completion, no stop error:
  - If the output buffer is empty, load `data_out` and set `data_valid`.
  - If the buffer is full and not being accepted that cycle, pulse `overrun` and keep the old word.
  - If accept and completion coincide, the new word loads and `data_valid` stays 1.
  - Go to IDLE immediately, without waiting out the rest of the stop bit.
- Stop bit sampled 0:
  - Pulse `frame_error`; the word is discarded.
  - If all data bits were 0, set `break_det`.
  - Go to WAIT_IDLE. `break_det` clears on the exit from WAIT_IDLE.
- A parity error pulses `parity_error`, but the word is still delivered.
- `data_valid` clears on the edge where `data_valid && data_ready`.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, all pulse outputs 0, `break_det`=0, `state`=IDLE. Tick and sample counters are 0.
- Reset mid-frame aborts the frame. Any held word is lost.
- Latency: a falling edge on `rx` is seen in IDLE 2 cycles later. `data_valid` rises 1 cycle after the final stop-bit vote tick.
- Back-to-back frames with only the configured stop bits are received without loss.
- Error pulses last exactly one `clk` cycle. `frame_error` and `overrun` are mutually exclusive.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state exists;
  - the frame is start + DATA_BITS + parity + STOP_BITS;
  - `parity_error` is live.
- `UART_RX_PARITY_EN` undefined:
  - DATA goes straight to STOP;
  - `parity_error` is constant 0;
  - `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg` holds:
  - the state enum/localparams (IDLE..WAIT_IDLE, 3-bit);
  - the divisor function `baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE)`.
- The `uart_pkg` contents are shared with a future TX block.
- Sub-module `uart_baud_tick` contains the tick counter, with `clear` and `tick` ports. The rest of the block is a single FSM.

## Test plan
- Defaults, macro off, `data_ready`=1: send 0x00..0x07 and 0xAA, 0x55, 0xFF at 115200 8N2 (bit period 8680 ns). Each byte appears on `data_out` with a single `data_valid` pulse, no errors.
- 2 µs low glitch on `rx` -> false start: FSM returns to IDLE, no `data_valid`, no flags.
- 0xA5 with stop bit driven 0 -> `frame_error` pulse, no `data_valid`, `state`=5 until the line is high for 1 bit time.
- `data_ready`=0, send 0x12 then 0x34 -> `data_out`=0x12 is held and `overrun` pulses once. Then `data_ready`=1 accepts 0x12 and `data_valid` drops.
- Line held low for 20 bit times -> `frame_error` and `break_det`=1. `break_det` clears 1 bit time after `rx` returns high.
- Macro on, `PARITY_ODD`=0, DATA_BITS=7, STOP_BITS=1: send 0x41 with parity 1 -> `parity_error` pulse and `data_out`=0x41. Send with parity 0 -> no error.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and the future transmitter.
// Holds the 3-bit state encoding, the baud divisor function and small bit helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_IDLE = 3'd5
   } uart_state_e;

   // Clock cycles per oversample tick, truncated toward zero.
   function automatic int baud_div(input int clk_freq, input int baud_rate, input int oversample);
      return clk_freq / (baud_rate * oversample);
   endfunction

   // Two-out-of-three vote used for every received bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Parity bit the transmitter should have sent for word d (odd=1 selects odd parity).
   function automatic logic calc_parity(input logic [8:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator.
// Emits a one-cycle tick every DIV clocks; held at zero while clear is high so the
// first tick after a start edge lands a full tick period later.
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

   logic [CW-1:0] cnt_r;
   logic          tick_r;

   // Divider counter with registered tick output.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_r  <= CNT_ZERO;
         tick_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r  <= CNT_ZERO;
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + CNT_ONE;
         tick_r <= 1'b0;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with 16x oversampling, 3-sample majority
// vote, valid/ready output buffer and overrun / frame error / break reporting.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 2,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_error,
   output logic                 parity_error,
   output logic                 overrun,
   output logic                 break_det,
   output logic [2:0]           state
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int SW  = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] S_ZERO = SW'(32'd0);
   localparam logic [SW-1:0] S_ONE  = SW'(32'd1);
   localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic [DATA_BITS-1:0] D_ZERO = {DATA_BITS{1'b0}};

   uart_state_e          state_r, state_next_s;
   logic                 rx_meta_r, rx_sync_r;
   logic                 tick_s, clear_s;
   logic [SW-1:0]        s_r, s_next_s;
   logic [3:0]           bit_r, bit_next_s;
   logic                 stop_r, stop_next_s;
   logic                 v0_r, v0_next_s, v1_r, v1_next_s;
   logic [DATA_BITS-1:0] shift_r, shift_next_s, data_r, data_next_s;
   logic                 valid_r, valid_next_s;
   logic                 ferr_r, ferr_next_s, ovr_r, ovr_next_s, brk_r, brk_next_s;
   logic                 vote_s, vote_now_s, bit_end_s, accept_s;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic                 par_r, par_next_s, perr_r, perr_next_s;
`endif

   // Two-flop synchroniser for the asynchronous line; idles high out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   assign clear_s = (state_r == IDLE);

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_s),
      .tick  (tick_s)
   );

   assign vote_s     = maj3(v0_r, v1_r, rx_sync_r);
   assign vote_now_s = tick_s && (s_r == S_V2);
   assign bit_end_s  = tick_s && (s_r == S_LAST);
   assign accept_s   = valid_r && data_ready;

   // Next-state, sampling, shift register and output buffer decisions.
   always_comb begin
      state_next_s = state_r;
      bit_next_s   = bit_r;
      stop_next_s  = stop_r;
      shift_next_s = shift_r;
      data_next_s  = data_r;
      ferr_next_s  = 1'b0;
      ovr_next_s   = 1'b0;
      brk_next_s   = brk_r;
`ifdef UART_RX_PARITY_EN
      par_next_s   = par_r;
      perr_next_s  = 1'b0;
`endif
      if (tick_s && (s_r == S_V0)) v0_next_s = rx_sync_r;
      else                         v0_next_s = v0_r;
      if (tick_s && (s_r == S_V1)) v1_next_s = rx_sync_r;
      else                         v1_next_s = v1_r;
      if (bit_end_s)   s_next_s = S_ZERO;
      else if (tick_s) s_next_s = s_r + S_ONE;
      else             s_next_s = s_r;
      if (accept_s) valid_next_s = 1'b0;
      else          valid_next_s = valid_r;

      case (state_r)
         IDLE: begin
            s_next_s = S_ZERO;
            if (!rx_sync_r) state_next_s = START;
            else            state_next_s = IDLE;
         end
         START: begin
            if (vote_now_s && vote_s) begin
               state_next_s = IDLE;            // glitch, not a start bit
            end else if (bit_end_s) begin
               state_next_s = DATA;
               bit_next_s   = 4'd0;
            end else begin
               state_next_s = START;
            end
         end
         DATA: begin
            if (vote_now_s) shift_next_s = {vote_s, shift_r[DATA_BITS-1:1]};
            else            shift_next_s = shift_r;
            if (bit_end_s && (bit_r == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
               state_next_s = PARITY;
`else
               state_next_s = STOP;
`endif
               stop_next_s = 1'b0;
            end else if (bit_end_s) begin
               bit_next_s = bit_r + 4'd1;
            end else begin
               state_next_s = DATA;
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (vote_now_s) par_next_s = vote_s;
            else            par_next_s = par_r;
`endif
            if (bit_end_s) begin
               state_next_s = STOP;
               stop_next_s  = 1'b0;
            end else begin
               state_next_s = PARITY;
            end
         end
         STOP: begin
            if (vote_now_s && !vote_s) begin
               ferr_next_s  = 1'b1;
               brk_next_s   = (shift_r == D_ZERO);
               state_next_s = WAIT_IDLE;
               s_next_s     = S_ZERO;
            end else if (vote_now_s && (stop_r == STOP_LAST)) begin
               // Frame complete: leave mid stop bit so the next start edge is caught.
               state_next_s = IDLE;
               if (!valid_r || accept_s) begin
                  data_next_s  = shift_r;
                  valid_next_s = 1'b1;
               end else begin
                  ovr_next_s = 1'b1;
               end
`ifdef UART_RX_PARITY_EN
               perr_next_s = (par_r != calc_parity(9'(shift_r), PAR_ODD));
`endif
            end else if (bit_end_s) begin
               stop_next_s = stop_r + 1'b1;
            end else begin
               state_next_s = STOP;
            end
         end
         WAIT_IDLE: begin
            if (!rx_sync_r) begin
               s_next_s     = S_ZERO;          // restart the idle bit timer
               state_next_s = WAIT_IDLE;
            end else if (bit_end_s) begin
               state_next_s = IDLE;
               brk_next_s   = 1'b0;
            end else begin
               state_next_s = WAIT_IDLE;
            end
         end
         default: begin
            state_next_s = IDLE;
            s_next_s     = S_ZERO;
         end
      endcase
   end

   // State and datapath registers; reset abandons any frame and any held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         s_r     <= S_ZERO;
         bit_r   <= 4'd0;
         stop_r  <= 1'b0;
         v0_r    <= 1'b1;
         v1_r    <= 1'b1;
         shift_r <= D_ZERO;
         data_r  <= D_ZERO;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         ovr_r   <= 1'b0;
         brk_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         s_r     <= s_next_s;
         bit_r   <= bit_next_s;
         stop_r  <= stop_next_s;
         v0_r    <= v0_next_s;
         v1_r    <= v1_next_s;
         shift_r <= shift_next_s;
         data_r  <= data_next_s;
         valid_r <= valid_next_s;
         ferr_r  <= ferr_next_s;
         ovr_r   <= ovr_next_s;
         brk_r   <= brk_next_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Received parity bit and registered parity error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         par_r  <= 1'b0;
         perr_r <= 1'b0;
      end else begin
         par_r  <= par_next_s;
         perr_r <= perr_next_s;
      end
   end
   assign parity_error = perr_r;
`else
   assign parity_error = 1'b0;
`endif

   assign data_out    = data_r;
   assign data_valid  = valid_r;
   assign frame_error = ferr_r;
   assign overrun     = ovr_r;
   assign break_det   = brk_r;
   assign state       = state_r;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed, table-driven bench for uart_rx_cfg.
// Runs at a fast line rate (divisor 4, 64 clocks per bit) to keep the run short.
// Define UART_RX_PARITY_EN for the 7-bit, 1-stop, even-parity configuration.
module tb_uart_rx_cfg;
   import uart_pkg::*;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 781_250;
   localparam int OS       = 16;
   localparam int BIT      = 64;            // 16 samples x divisor 4
`ifdef UART_RX_PARITY_EN
   localparam int DB = 7, SB = 1, PEN = 1;
`else
   localparam int DB = 8, SB = 2, PEN = 0;
`endif
   localparam logic [8:0] MASK = 9'((1 << DB) - 1);

   typedef struct {
      logic [8:0] data;
      logic       par;
      logic [8:0] exp_data;
      logic       exp_perr;
   } vec_t;

   logic          clk, rst, rx, data_ready;
   logic [DB-1:0] data_out;
   logic          data_valid, frame_error, parity_error, overrun, break_det;
   logic [2:0]    state;

   int n_checks = 0, n_fail = 0;
   int n_valid = 0, n_vcyc = 0, n_ferr = 0, n_perr = 0, n_ovr = 0;
   logic [8:0] last_data = 9'h000;
   logic dv_q = 1'b0;
   vec_t vecs[$];

   uart_rx_cfg #(
      .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
      .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(0)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .data_valid(data_valid),
      .data_ready(data_ready), .frame_error(frame_error), .parity_error(parity_error),
      .overrun(overrun), .break_det(break_det), .state(state)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Event monitor on the falling edge: counts pulses and captures delivered words.
   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid && !dv_q) begin
            n_valid++;
            last_data = 9'(data_out);
         end
         if (data_valid)   n_vcyc++;
         if (frame_error)  n_ferr++;
         if (parity_error) n_perr++;
         if (overrun)      n_ovr++;
         dv_q = data_valid;
      end else begin
         dv_q = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      wait_cyc(BIT);
   endtask

   function automatic logic epar(input logic [8:0] d);
      logic [8:0] m;
      m = d & MASK;
      return ^m;
   endfunction

   task automatic send_frame(input logic [8:0] d, input logic par, input logic stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i]);
      if (PEN != 0) drive_bit(par);
      for (int i = 0; i < SB; i++) drive_bit(stop_v);
      rx = 1'b1;
   endtask

   initial begin
      int v0, c0, f0, p0, o0;
      logic [8:0] bytes_a [11];
      logic [8:0] d;
      bytes_a = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006, 9'h007,
                  9'h0AA, 9'h055, 9'h0FF};
`ifdef UART_RX_PARITY_EN
      vecs.push_back('{9'h041, 1'b1, 9'h041, 1'b1});   // two ones: even parity wants 0
      vecs.push_back('{9'h041, 1'b0, 9'h041, 1'b0});
      vecs.push_back('{9'h07F, 1'b1, 9'h07F, 1'b0});   // seven ones: parity 1 is correct
      vecs.push_back('{9'h000, 1'b1, 9'h000, 1'b1});
`else
      for (int i = 0; i < 11; i++) vecs.push_back('{bytes_a[i], 1'b0, bytes_a[i], 1'b0});
`endif

      // Reset state
      rst = 1'b1; rx = 1'b1; data_ready = 1'b1;
      wait_cyc(3);
      check("reset state", 32'(state), 32'd0);
      check("reset data_valid", 32'(data_valid), 32'd0);
      check("reset data_out", 32'(data_out), 32'd0);
      check("reset flags", 32'({frame_error, parity_error, overrun, break_det}), 32'd0);
      check("baud_div default", 32'(baud_div(50_000_000, 115200, 16)), 32'd27);
      rst = 1'b0;
      wait_cyc(2 * BIT);

      // Table of frames sent back to back, one word and one valid cycle each
      for (int i = 0; i < vecs.size(); i++) begin
         v0 = n_valid; c0 = n_vcyc; f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
         send_frame(vecs[i].data, vecs[i].par, 1'b1);
         check($sformatf("vec%0d valid", i), 32'(n_valid - v0), 32'd1);
         check($sformatf("vec%0d valid cycles", i), 32'(n_vcyc - c0), 32'd1);
         check($sformatf("vec%0d data", i), 32'(last_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d parity_error", i), 32'(n_perr - p0), 32'(vecs[i].exp_perr));
         check($sformatf("vec%0d ferr+ovr", i), 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);
      end
      wait_cyc(BIT);

      // Short low glitch: false start, back to IDLE with nothing reported
      v0 = n_valid; f0 = n_ferr; p0 = n_perr;
      rx = 1'b0;
      wait_cyc(8);
      check("glitch enters START", 32'(state), 32'd1);
      wait_cyc(8);
      rx = 1'b1;
      wait_cyc(BIT);
      check("glitch state", 32'(state), 32'd0);
      check("glitch no valid", 32'(n_valid - v0), 32'd0);
      check("glitch no flags", 32'((n_ferr - f0) + (n_perr - p0)), 32'd0);

      // Stop bit low: frame error, word dropped, WAIT_IDLE until one idle bit
      v0 = n_valid; f0 = n_ferr;
      d = 9'h0A5 & MASK;
      send_frame(d, epar(d), 1'b0);
      check("ferr pulse", 32'(n_ferr - f0), 32'd1);
      check("ferr no valid", 32'(n_valid - v0), 32'd0);
      check("ferr state", 32'(state), 32'd5);
      check("ferr no break", 32'(break_det), 32'd0);
      wait_cyc(BIT / 2);
      check("ferr wait half bit", 32'(state), 32'd5);
      wait_cyc(BIT / 2 + 24);
      check("ferr back to idle", 32'(state), 32'd0);

      // Overrun: second word arrives while the first is unaccepted
      data_ready = 1'b0;
      o0 = n_ovr; f0 = n_ferr;
      send_frame(9'h012, epar(9'h012), 1'b1);
      check("ovr first valid", 32'(data_valid), 32'd1);
      check("ovr first data", 32'(data_out), 32'h12);
      send_frame(9'h034, epar(9'h034), 1'b1);
      check("ovr data held", 32'(data_out), 32'h12);
      check("ovr pulse", 32'(n_ovr - o0), 32'd1);
      check("ovr no ferr", 32'(n_ferr - f0), 32'd0);
      check("ovr still valid", 32'(data_valid), 32'd1);
      data_ready = 1'b1;
      wait_cyc(1);
      check("accept clears valid", 32'(data_valid), 32'd0);
      wait_cyc(BIT);

      // Break: line low for 20 bit times
      f0 = n_ferr;
      rx = 1'b0;
      wait_cyc(20 * BIT);
      check("break ferr", 32'(n_ferr - f0), 32'd1);
      check("break_det set", 32'(break_det), 32'd1);
      check("break state", 32'(state), 32'd5);
      rx = 1'b1;
      wait_cyc(BIT / 2);
      check("break held half bit", 32'(break_det), 32'd1);
      wait_cyc(BIT / 2 + 24);
      check("break cleared", 32'(break_det), 32'd0);
      check("break idle", 32'(state), 32'd0);

      // Reset in mid frame discards the held word and the partial frame
      data_ready = 1'b0;
      send_frame(9'h05A & MASK, epar(9'h05A), 1'b1);
      check("pre-reset valid", 32'(data_valid), 32'd1);
      rx = 1'b0;
      wait_cyc(3 * BIT);
      rst = 1'b1;
      wait_cyc(2);
      check("midreset state", 32'(state), 32'd0);
      check("midreset valid", 32'(data_valid), 32'd0);
      check("midreset data", 32'(data_out), 32'd0);
      rst = 1'b0; rx = 1'b1; data_ready = 1'b1;
      wait_cyc(2 * BIT);

      // Recovery frame after reset
      v0 = n_valid;
      send_frame(9'h03C, epar(9'h03C), 1'b1);
      check("recover valid", 32'(n_valid - v0), 32'd1);
      check("recover data", 32'(last_data), 32'h3C);
      wait_cyc(BIT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
